rgb_matrix_scanner: RTL and testbench
=====================================

RGB_MATRIX_SCANNER -- requirements
Module: rgb_matrix_scanner

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 1000: number of clock cycles each column is driven; legal range 4..65535.
REQ-002 SHALL have parameter BLANK_CYCLES, default 16: number of all-off cycles before each column; legal range 1..255.
REQ-003 clock  in  1  the only clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 wr_en  in  1  pixel write strobe into the shadow buffer.
REQ-006 wr_col  in  2  target column 0..3.
REQ-007 wr_row  in  2  target row 0..2; the value 3 is illegal.
REQ-008 wr_rgb  in  3  pixel colour {R,G,B}; 1 = lit.
REQ-009 commit  in  1  single-cycle request to swap the shadow buffer into the display buffer.
REQ-010 brightness  in  2  global intensity; used only when RGB_SCAN_PWM_EN is defined.
REQ-011 wr_ready  out  1  high when writes and commits are accepted.
REQ-012 frame_start  out  1  one-cycle pulse when column 0 starts its blank interval.
REQ-013 row1, row2, row3  out  3 each  active-low {R,G,B} drive for rows 0..2.
REQ-014 RGB_Column  out  4  active-low one-hot column enable; bit n = column n.

Function
REQ-015 Two 12x3-bit buffers SHALL exist: shadow (write side) and display (scan side).
REQ-016 wr_en with wr_ready=1 and wr_row<3 SHALL write wr_rgb into shadow[wr_col][wr_row] at the next edge; wr_row=3 SHALL be ignored.
REQ-017 Writes SHALL never alter the display buffer directly.
REQ-018 commit with wr_ready=1 SHALL set pending at the next edge; wr_ready SHALL equal !pending.
REQ-019 While pending=1, wr_en and commit SHALL be ignored.
REQ-020 Scan FSM states: BLANK and DRIVE; a cycle counter and a 2-bit column index.
REQ-021 BLANK SHALL last BLANK_CYCLES cycles, with RGB_Column=4'b1111 and all rows 3'b111; it then moves to DRIVE.
REQ-022 DRIVE SHALL last DWELL_CYCLES cycles, with RGB_Column bit col low and rowN = ~display[col][N-1]; it then moves to BLANK of col+1, wrapping 3 to 0.
REQ-023 On the DRIVE-to-BLANK transition from column 3, if pending=1, the display buffer SHALL be loaded from shadow and pending SHALL clear at that edge.
REQ-024 frame_start SHALL pulse in the first BLANK cycle of column 0, including the first such cycle after reset.
REQ-025 A commit arriving in the same cycle as the column-3 frame edge SHALL set pending and SHALL take effect at the next frame edge.
REQ-026 Outputs SHALL be registered; the column and rows SHALL change on the same edge, so both are never active across different columns.
REQ-027 A write in the same cycle as a swap SHALL go to shadow only; the swap SHALL copy the pre-write shadow contents.

Reset
REQ-028 Reset SHALL set: both buffers to all zeros, pending=0, wr_ready=1, state=BLANK, col=0, counter=0, frame_start=0, rows=3'b111, RGB_Column=4'b1111.
REQ-029 Reset asserted mid-DRIVE SHALL blank the outputs at the next edge; scanning SHALL restart at column 0 BLANK on the first cycle after release.

Configuration
REQ-030 Macro RGB_SCAN_PWM_EN.
- Defined: within DRIVE, rows SHALL be lit only while counter < ((brightness+1)*DWELL_CYCLES)/4 and SHALL be 3'b111 afterwards; RGB_Column SHALL stay asserted for the whole DWELL.
- Undefined: the brightness input SHALL be ignored and rows SHALL be lit for the full DWELL.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=1)
REQ-031 Reset, then idle:
- Column-0 BLANK for 1 cycle, then RGB_Column=1110 for 4 cycles, then 1101.
- frame_start pulses every 20 cycles.
- All rows stay 111.
REQ-032 Write (col1,row0,rgb=100), then commit:
- wr_ready drops; display updates at the next frame edge; wr_ready rises at that edge.
- Thereafter row1=011 only while RGB_Column=1101.
REQ-033 wr_row=3 write, and a write or commit issued while wr_ready=0:
- No buffer change and no output change.
REQ-034 Commit in the exact column-3 DRIVE-to-BLANK cycle:
- No swap that frame; swap occurs 20 cycles later.
REQ-035 Reset asserted for 1 cycle mid-DRIVE of column 2:
- Next edge gives all outputs off and buffers cleared; then column-0 BLANK.
REQ-036 With RGB_SCAN_PWM_EN, brightness=1, DWELL_CYCLES=8, pixel lit:
- Row low for 4 of 8 DRIVE cycles.
- Without the macro: row low for all 8.

Source files
------------

// File: rtl/rgb_matrix_scanner.sv
// 4x3 RGB matrix column scanner with double-buffered pixel memory.
// Optional macro RGB_SCAN_PWM_EN enables brightness-based row PWM.
module rgb_matrix_scanner #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] wr_col,
    input  logic [1:0] wr_row,
    input  logic [2:0] wr_rgb,
    input  logic       commit,
    input  logic [1:0] brightness,
    output logic       wr_ready,
    output logic       frame_start,
    output logic [2:0] row1,
    output logic [2:0] row2,
    output logic [2:0] row3,
    output logic [3:0] RGB_Column
);

    typedef enum logic {
        BLANK,
        DRIVE
    } state_t;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

    state_t           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [1:0]       col_q, col_d;
    logic [11:0][2:0] shadow_q, shadow_d;
    logic [11:0][2:0] display_q, display_d;
    logic             pending_q, pending_d;
    logic             ready_q, ready_d;
    logic             fs_q, fs_d;
    logic [2:0]       row1_q, row1_d;
    logic [2:0]       row2_q, row2_d;
    logic [2:0]       row3_q, row3_d;
    logic [3:0]       colen_q, colen_d;

    logic             accept;
    logic             frame_edge;
    logic             swap;
    logic             lit_window;
    logic [3:0]       wr_idx;
    logic [3:0]       rd_base;

    // Pixel index is col*3 + row within the flattened 12-entry buffer
    assign wr_idx  = {1'b0, wr_col, 1'b0} + {2'b00, wr_col} + {2'b00, wr_row};
    assign rd_base = {1'b0, col_q, 1'b0} + {2'b00, col_q};
    assign accept  = !pending_q;

`ifdef RGB_SCAN_PWM_EN
    logic [31:0] lit_limit;
    assign lit_limit  = ((32'(brightness) + 32'd1) * 32'(DWELL_CYCLES)) >> 2;
    assign lit_window = {16'd0, cnt_q} < lit_limit;
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign lit_window        = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        col_d      = col_q;
        frame_edge = 1'b0;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d    = BLANK;
                    cnt_d      = '0;
                    col_d      = col_q + 2'd1;
                    frame_edge = (col_q == 2'd3);
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // The swap copies the shadow as it stood before this cycle's write
    always_comb begin
        swap      = frame_edge && pending_q;
        shadow_d  = shadow_q;
        display_d = display_q;
        pending_d = pending_q;
        if (wr_en && accept && (wr_row != 2'd3)) begin
            shadow_d[wr_idx] = wr_rgb;
        end
        if (swap) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end else if (commit && accept) begin
            pending_d = 1'b1;
        end
        ready_d = !pending_d;
    end

    // Output registers present the state held during the previous cycle
    always_comb begin
        colen_d = 4'b1111;
        row1_d  = 3'b111;
        row2_d  = 3'b111;
        row3_d  = 3'b111;
        fs_d    = (state_q == BLANK) && (col_q == 2'd0) && (cnt_q == 16'd0);
        if (state_q == DRIVE) begin
            colen_d = ~(4'b0001 << col_q);
            if (lit_window) begin
                row1_d = ~display_q[rd_base];
                row2_d = ~display_q[rd_base + 4'd1];
                row3_d = ~display_q[rd_base + 4'd2];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            col_q     <= '0;
            shadow_q  <= '0;
            display_q <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            fs_q      <= 1'b0;
            row1_q    <= 3'b111;
            row2_q    <= 3'b111;
            row3_q    <= 3'b111;
            colen_q   <= 4'b1111;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            shadow_q  <= shadow_d;
            display_q <= display_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            fs_q      <= fs_d;
            row1_q    <= row1_d;
            row2_q    <= row2_d;
            row3_q    <= row3_d;
            colen_q   <= colen_d;
        end
    end

    assign wr_ready    = ready_q;
    assign frame_start = fs_q;
    assign row1        = row1_q;
    assign row2        = row2_q;
    assign row3        = row3_q;
    assign RGB_Column  = colen_q;

endmodule

// File: tb/tb_rgb_matrix_scanner.sv
// Directed self-checking bench for rgb_matrix_scanner.
// Main DUT: DWELL=4, BLANK=1; second DUT: DWELL=8 for the PWM duty check.
module tb_rgb_matrix_scanner;

    localparam int DW    = 4;
    localparam int BL    = 1;
    localparam int SLOT  = DW + BL;
    localparam int FRAME = 4 * SLOT;

    logic       clock = 1'b0;
    logic       reset;
    logic       wr_en, commit;
    logic [1:0] wr_col, wr_row, brightness;
    logic [2:0] wr_rgb;
    logic       wr_ready, frame_start;
    logic [2:0] row1, row2, row3;
    logic [3:0] RGB_Column;

    logic       wr_en8, commit8;
    logic [1:0] wr_col8, wr_row8, brightness8;
    logic [2:0] wr_rgb8;
    logic       wr_ready8, frame_start8;
    logic [2:0] row1_8, row2_8, row3_8;
    logic [3:0] col8;

    rgb_matrix_scanner #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_col(wr_col),
        .wr_row(wr_row), .wr_rgb(wr_rgb), .commit(commit),
        .brightness(brightness), .wr_ready(wr_ready),
        .frame_start(frame_start), .row1(row1), .row2(row2), .row3(row3),
        .RGB_Column(RGB_Column)
    );

    rgb_matrix_scanner #(.DWELL_CYCLES(8), .BLANK_CYCLES(BL)) dut8 (
        .clock(clock), .reset(reset), .wr_en(wr_en8), .wr_col(wr_col8),
        .wr_row(wr_row8), .wr_rgb(wr_rgb8), .commit(commit8),
        .brightness(brightness8), .wr_ready(wr_ready8),
        .frame_start(frame_start8), .row1(row1_8), .row2(row2_8),
        .row3(row3_8), .RGB_Column(col8)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         len;
        logic [3:0] col;
        logic       fs;
        logic [2:0] rows;
    } seg_t;

    seg_t       tbl[9];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         s        = 0;
    bit         chk      = 1'b0;
    logic [2:0] exp_disp[4][3];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, s);
        end
    endtask

    task automatic check_pos();
        int p, c;
        logic [3:0] ec;
        logic [2:0] e1, e2, e3;
        p = (s - 1) % FRAME;
        c = p / SLOT;
        if (p % SLOT == 0) begin
            ec = 4'b1111;
            e1 = 3'b111;
            e2 = 3'b111;
            e3 = 3'b111;
        end else begin
            ec = ~(4'b0001 << c);
            e1 = ~exp_disp[c][0];
            e2 = ~exp_disp[c][1];
            e3 = ~exp_disp[c][2];
        end
        check("column", RGB_Column, ec);
        check("row1", row1, e1);
        check("row2", row2, e2);
        check("row3", row3, e3);
        check("frame_start", frame_start, p == 0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        s++;
        if (chk) check_pos();
    endtask

    task automatic run_table();
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < tbl[i].len; j++) begin
                tick();
                check("tbl column", RGB_Column, tbl[i].col);
                check("tbl frame_start", frame_start, tbl[i].fs);
                check("tbl row1", row1, tbl[i].rows);
                check("tbl row2", row2, tbl[i].rows);
                check("tbl row3", row3, tbl[i].rows);
            end
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 3; r++)
                exp_disp[c][r] = 3'b000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int w, lit, drv, exp_lit;
        tbl[0] = '{1, 4'b1111, 1'b1, 3'b111};
        tbl[1] = '{4, 4'b1110, 1'b0, 3'b111};
        tbl[2] = '{1, 4'b1111, 1'b0, 3'b111};
        tbl[3] = '{4, 4'b1101, 1'b0, 3'b111};
        tbl[4] = '{1, 4'b1111, 1'b0, 3'b111};
        tbl[5] = '{4, 4'b1011, 1'b0, 3'b111};
        tbl[6] = '{1, 4'b1111, 1'b0, 3'b111};
        tbl[7] = '{4, 4'b0111, 1'b0, 3'b111};
        tbl[8] = '{1, 4'b1111, 1'b1, 3'b111};

        reset = 1'b1;
        wr_en = 0; commit = 0; wr_col = 0; wr_row = 0; wr_rgb = 0;
        brightness = 2'd3;
        wr_en8 = 0; commit8 = 0; wr_col8 = 0; wr_row8 = 0; wr_rgb8 = 0;
        brightness8 = 2'd1;
        clear_model();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        s = 0;
        check("reset column", RGB_Column, 4'b1111);
        check("reset rows", {row1, row2, row3}, 9'h1ff);
        check("reset frame_start", frame_start, 1'b0);
        check("reset wr_ready", wr_ready, 1'b1);

        run_table();
        chk = 1'b1;

        wr_en = 1; wr_col = 2'd1; wr_row = 2'd0; wr_rgb = 3'b100;
        tick();
        wr_en = 0;
        check("ready after write", wr_ready, 1'b1);
        commit = 1;
        tick();
        commit = 0;
        check("ready after commit", wr_ready, 1'b0);
        while (s < 39) tick();
        check("ready before swap", wr_ready, 1'b0);
        tick();
        check("ready at swap", wr_ready, 1'b1);
        exp_disp[1][0] = 3'b100;
        while (s < 61) tick();

        wr_en = 1; wr_col = 2'd2; wr_row = 2'd3; wr_rgb = 3'b111;
        tick();
        wr_en = 0; commit = 1;
        tick();
        commit = 0;
        check("ready after commit 2", wr_ready, 1'b0);
        wr_en = 1; wr_col = 2'd2; wr_row = 2'd1; wr_rgb = 3'b111;
        tick();
        wr_en = 0; commit = 1;
        tick();
        commit = 0;
        check("ready ignored commit", wr_ready, 1'b0);
        while (s < 80) tick();
        check("ready at swap 2", wr_ready, 1'b1);
        tick();
        check("ready after swap 2", wr_ready, 1'b1);

        while (s < 85) tick();
        wr_en = 1; wr_col = 2'd3; wr_row = 2'd2; wr_rgb = 3'b010;
        tick();
        wr_en = 0;
        while (s < 99) tick();
        commit = 1;
        tick();
        commit = 0;
        check("ready edge commit", wr_ready, 1'b0);
        while (s < 119) tick();
        check("ready before late swap", wr_ready, 1'b0);
        tick();
        check("ready at late swap", wr_ready, 1'b1);
        exp_disp[3][2] = 3'b010;
        while (s < 152) tick();

        check("mid drive column", RGB_Column, 4'b1011);
        reset = 1'b1;
        chk = 1'b0;
        tick();
        check("mid reset column", RGB_Column, 4'b1111);
        check("mid reset rows", {row1, row2, row3}, 9'h1ff);
        check("mid reset frame_start", frame_start, 1'b0);
        check("mid reset wr_ready", wr_ready, 1'b1);
        reset = 1'b0;
        s = 0;
        clear_model();
        run_table();
        chk = 1'b1;

        wr_en8 = 1; wr_col8 = 2'd0; wr_row8 = 2'd0; wr_rgb8 = 3'b100;
        tick();
        wr_en8 = 0; commit8 = 1;
        tick();
        commit8 = 0;
        w = 0;
        while (!wr_ready8 && w < 200) begin
            tick();
            w++;
        end
        check("dut8 swap", wr_ready8, 1'b1);
        lit = 0;
        drv = 0;
        for (int k = 0; k < 36; k++) begin
            tick();
            if (col8 == 4'b1110) begin
                drv++;
                if (row1_8 == 3'b011) lit++;
            end
        end
`ifdef RGB_SCAN_PWM_EN
        exp_lit = 4;
`else
        exp_lit = 8;
`endif
        check("dut8 drive cycles", drv, 8);
        check("dut8 lit cycles", lit, exp_lit);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
